ad100_lsu: RTL and testbench

Load/store unit between the ad100 CPU datapath and its word-wide, single-port synchronous RAM. It accepts one memory request at a time from the CPU and handles LB/LBU/LH/LHU/LW and SB/SH/SW. Loads get byte/halfword lane extraction and sign/zero extension. SB/SH use read-modify-write, because the RAM has no byte enables. Misaligned or illegal requests return an error response without touching RAM.

---
 rtl/ad100_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_ad100_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad100_lsu.sv
// ad100_lsu: load/store unit between the ad100 CPU datapath and a word-wide,
// single-port synchronous RAM (read data valid the cycle after mem_re).
// Handles LB/LBU/LH/LHU/LW and SB/SH/SW. Sub-word stores use
// read-modify-write because the RAM has no byte enables. Illegal or
// misaligned requests get an error response and never touch the RAM.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    CPU request handshake (ready only when idle)
//   req_we, req_funct3     store flag and RV32I width/sign code
//   req_addr, req_wdata    byte address and store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response, extended load data, error flag
//   mem_addr/mem_re/mem_rdata    RAM word address, read strobe, read data
//   mem_we/mem_wdata             RAM full-word write strobe and data
module ad100_lsu #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t state, state_d;

  // Latched request fields (SW data goes straight to mem_wdata at accept,
  // so only the low half is kept for the sub-word merge).
  logic        we_q,   we_d;
  logic [2:0]  f3_q,   f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wd_q,   wd_d;

  logic              rsp_valid_d, rsp_err_d, mem_re_d, mem_we_d;
  logic [31:0]       rsp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic        accept, illegal, misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  // Address bits above the RAM size wrap and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0])
              || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction and merge operate on the RAM word arriving in CAP.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_val = mem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (f3_q == 3'b000) begin
      case (lane_q)
        2'd0: merged[7:0]   = wd_q[7:0];
        2'd1: merged[15:8]  = wd_q[7:0];
        2'd2: merged[23:16] = wd_q[7:0];
        2'd3: merged[31:24] = wd_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wd_q;
    end else begin
      merged[15:0] = wd_q;
    end
  end

  always_comb begin
    state_d     = state;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wd_d        = wd_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          we_d       = req_we;
          f3_d       = req_funct3;
          lane_d     = req_addr[1:0];
          wd_d       = req_wdata[15:0];
          mem_addr_d = req_addr[ADDR_W+1:2];
          if (illegal || misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d  = RD;
            mem_re_d = 1'b1;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_val;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      wd_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      wd_q      <= wd_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_ad100_lsu.sv
// Directed self-checking bench for ad100_lsu with a behavioural
// synchronous RAM (one-cycle read latency, full-word writes).
module tb_ad100_lsu;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [31:0]   mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  ad100_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int both_cnt = 0, we_total = 0, rsp_total = 0;

  always @(negedge clk) begin
    if (mem_re && mem_we) both_cnt++;
    if (mem_we) we_total++;
    if (rsp_valid) rsp_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Per-request observations; cycle numbers are relative to the accept cycle T.
  int          re_cnt, re_cyc, we_cnt, we_cyc, rsp_cnt, rsp_cyc;
  logic [AW-1:0] re_addr, we_addr;
  logic [31:0] we_data, r_data;
  logic        r_err;

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    re_cnt = 0; we_cnt = 0; rsp_cnt = 0;
    re_cyc = -1; we_cyc = -1; rsp_cyc = -1;
    re_addr = '0; we_addr = '0; we_data = '0; r_data = '0; r_err = 1'b0;
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (mem_re) begin re_cnt++; re_cyc = k; re_addr = mem_addr; end
      if (mem_we) begin we_cnt++; we_cyc = k; we_addr = mem_addr; we_data = mem_wdata; end
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = k; r_data = rsp_rdata; r_err = rsp_err; end
    end
  endtask

  task automatic expect_load(input string tag, input logic [31:0] exp);
    check({tag, "_rdata"},   r_data, exp);
    check({tag, "_err"},     32'(r_err), 32'd0);
    check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd3);
    check({tag, "_rsp_cnt"}, 32'(rsp_cnt), 32'd1);
    check({tag, "_re_cnt"},  32'(re_cnt), 32'd1);
    check({tag, "_re_cyc"},  32'(re_cyc), 32'd1);
    check({tag, "_re_addr"}, 32'(re_addr), 32'h040);
    check({tag, "_we_cnt"},  32'(we_cnt), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"},     32'(r_err), 32'd1);
    check({tag, "_rdata"},   r_data, 32'd0);
    check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd1);
    check({tag, "_re_cnt"},  32'(re_cnt), 32'd0);
    check({tag, "_we_cnt"},  32'(we_cnt), 32'd0);
  endtask

  task automatic expect_sub_store(input string tag, input logic [AW-1:0] wa, input logic [31:0] word);
    check({tag, "_re_cyc"},  32'(re_cyc), 32'd1);
    check({tag, "_re_cnt"},  32'(re_cnt), 32'd1);
    check({tag, "_we_cnt"},  32'(we_cnt), 32'd1);
    check({tag, "_we_cyc"},  32'(we_cyc), 32'd3);
    check({tag, "_we_addr"}, 32'(we_addr), 32'(wa));
    check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd4);
    check({tag, "_rdata"},   r_data, 32'd0);
    check({tag, "_err"},     32'(r_err), 32'd0);
    check({tag, "_ram"},     ram[wa], word);
  endtask

  task automatic expect_sw(input string tag, input logic [AW-1:0] wa, input logic [31:0] word);
    check({tag, "_we_cnt"},  32'(we_cnt), 32'd1);
    check({tag, "_we_cyc"},  32'(we_cyc), 32'd1);
    check({tag, "_we_addr"}, 32'(we_addr), 32'(wa));
    check({tag, "_we_data"}, we_data, word);
    check({tag, "_re_cnt"},  32'(re_cnt), 32'd0);
    check({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'd2);
    check({tag, "_rdata"},   r_data, 32'd0);
    check({tag, "_ram"},     ram[wa], word);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_mem_re"},    32'(mem_re), 32'd0);
    check({tag, "_mem_we"},    32'(mem_we), 32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int we0, rsp0;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Preload word 0x40 through the DUT with SW.
    run_req(1'b1, 3'b010, 32'h100, 32'h80FF7F01);
    expect_sw("sw_preload", 10'h040, 32'h80FF7F01);

    run_req(1'b0, 3'b000, 32'h103, 32'h0);  expect_load("lb_103",  32'hFFFFFF80);
    run_req(1'b0, 3'b100, 32'h103, 32'h0);  expect_load("lbu_103", 32'h00000080);
    run_req(1'b0, 3'b000, 32'h100, 32'h0);  expect_load("lb_100",  32'h00000001);
    run_req(1'b0, 3'b001, 32'h102, 32'h0);  expect_load("lh_102",  32'hFFFF80FF);
    run_req(1'b0, 3'b101, 32'h102, 32'h0);  expect_load("lhu_102", 32'h000080FF);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);  expect_load("lw_100",  32'h80FF7F01);

    run_req(1'b0, 3'b001, 32'h101, 32'h0);  expect_err("lh_misaligned");
    run_req(1'b1, 3'b100, 32'h100, 32'h0);  expect_err("lbu_we");
    run_req(1'b1, 3'b010, 32'h102, 32'h0);  expect_err("sw_misaligned");
    run_req(1'b0, 3'b011, 32'h100, 32'h0);  expect_err("f3_011");

    run_req(1'b1, 3'b000, 32'h101, 32'h123456AB);
    expect_sub_store("sb_101", 10'h040, 32'h80FFAB01);
    run_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
    expect_sub_store("sh_102", 10'h040, 32'hBEEFAB01);

    run_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    expect_sw("sw_104", 10'h041, 32'hDEADBEEF);

    // Back-to-back: valid stays high across LW 0x100 then SW 0x108.
    @(negedge clk);
    check("b2b_ready_T", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check("b2b_ready_busy", 32'(req_ready), 32'd0);
      check("b2b_no_we_busy", 32'(mem_we), 32'd0);
      if (k == 1) begin
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h108; req_wdata = 32'h0BADF00D;
      end
    end
    check("b2b_lw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("b2b_lw_rdata", rsp_rdata, 32'hBEEFAB01);
    @(posedge clk); #1;
    check("b2b_ready_T4", 32'(req_ready), 32'd1);
    check("b2b_rsp_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_sw_we",    32'(mem_we), 32'd1);
    check("b2b_sw_addr",  32'(mem_addr), 32'h042);
    check("b2b_sw_wdata", mem_wdata, 32'h0BADF00D);
    @(posedge clk); #1;
    check("b2b_sw_rsp", 32'(rsp_valid), 32'd1);
    check("b2b_sw_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("b2b_ram", ram[10'h042], 32'h0BADF00D);

    // Reset while an SB sits in CAP.
    we0 = we_total; rsp0 = rsp_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h000000CC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_ready_in_cap", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_reset_outputs("rst_after");
    check("rst_no_write", 32'(we_total - we0), 32'd0);
    check("rst_no_rsp", 32'(rsp_total - rsp0), 32'd0);
    check("rst_ram_unchanged", ram[10'h040], 32'hBEEFAB01);
    check("re_we_never_together", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
